// File: rtl/sig_freq_gen_if.sv
// Request channel of the square-wave source: frequency word with a
// valid/ready handshake and a one-cycle rejection strobe.
interface sig_freq_gen_if;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        freq_ready;
  logic        freq_err;

  modport master (
    output freq_hz,
    output freq_valid,
    input  freq_ready,
    input  freq_err
  );

  modport slave (
    input  freq_hz,
    input  freq_valid,
    output freq_ready,
    output freq_err
  );
endinterface

// File: rtl/sig_freq_gen.sv
// Phase-accumulator square-wave source. The requested frequency is turned into
// a phase increment by a bit-serial restoring divider and applied only at a wrap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; increment in use is stable
// DIV   | restoring division, one quotient bit per cycle, ACC_W cycles
// PEND  | new increment computed, waiting for wrap / inc==0 / en==0
module sig_freq_gen #(
  parameter logic [31:0] SYS_CLK_HZ = 32'd100_000_000,
  parameter int unsigned ACC_W      = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  sig_freq_gen_if.slave    req,
  output logic             sig_out,
  output logic             period_tick,
  output logic [ACC_W-1:0] cur_inc
);

  localparam int unsigned CNT_W   = $clog2(ACC_W);
  localparam logic [31:0] HALF_HZ = SYS_CLK_HZ >> 1;
  localparam logic [32:0] DIVISOR = {1'b0, SYS_CLK_HZ};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] quo;
  logic [32:0]      rem;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W:0]   acc_sum;
  logic             wrap;
  logic [32:0]      rem_sh;
  logic [32:0]      rem_sub;
  logic             q_bit;
  logic             commit;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, inc};
    wrap    = en & acc_sum[ACC_W];
    rem_sh  = rem << 1;
    q_bit   = (rem_sh >= DIVISOR);
    rem_sub = q_bit ? (rem_sh - DIVISOR) : rem_sh;
    commit  = wrap | (inc == '0) | ~en;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      inc            <= '0;
      quo            <= '0;
      rem            <= '0;
      cnt            <= '0;
      sig_out        <= 1'b0;
      period_tick    <= 1'b0;
      req.freq_ready <= 1'b1;
      req.freq_err   <= 1'b0;
    end else begin
      req.freq_err <= 1'b0;
      period_tick  <= wrap;

      // Accumulator always runs on the increment already in use; a commit
      // on the same edge only affects the following cycle.
      if (en) begin
        acc     <= acc_sum[ACC_W-1:0];
        sig_out <= acc_sum[ACC_W-1];
      end else begin
        acc     <= '0;
        sig_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req.freq_valid) begin
            if (req.freq_hz > HALF_HZ) begin
              req.freq_err <= 1'b1;
            end else begin
              rem            <= {1'b0, req.freq_hz};
              quo            <= '0;
              cnt            <= CNT_W'(ACC_W - 1);
              state          <= DIV;
              req.freq_ready <= 1'b0;
            end
          end
        end
        DIV: begin
          rem <= rem_sub;
          quo <= {quo[ACC_W-2:0], q_bit};
          if (cnt == '0) begin
            state <= PEND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PEND: begin
          if (commit) begin
            inc            <= quo;
            state          <= IDLE;
            req.freq_ready <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          req.freq_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cur_inc = inc;

endmodule

// File: tb/tb_sig_freq_gen.sv
// Directed bench for sig_freq_gen at SYS_CLK_HZ=1000, ACC_W=16: hand-written
// corner sequences followed by a table of requests with hand-computed increments.
module tb_sig_freq_gen;
  localparam int unsigned ACC_W = 16;

  logic             sys_clk;
  logic             rst_n;
  logic             en;
  logic             sig_out;
  logic             period_tick;
  logic [ACC_W-1:0] cur_inc;

  sig_freq_gen_if rq ();

  sig_freq_gen #(
    .SYS_CLK_HZ (32'd1000),
    .ACC_W      (ACC_W)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (rq),
    .sig_out     (sig_out),
    .period_tick (period_tick),
    .cur_inc     (cur_inc)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hz;
    logic        exp_err;
    logic [31:0] exp_inc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic request(input logic [31:0] hz);
    rq.freq_hz    = hz;
    rq.freq_valid = 1'b1;
    @(posedge sys_clk);
    #1 rq.freq_valid = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n;
    n = 0;
    while (!rq.freq_ready && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (!rq.freq_ready) chk(name, rq.freq_ready, 1);
  endtask

  initial begin
    int          n;
    int          cnt_a;
    int          cnt_b;
    logic [7:0]  pat;
    logic        prev;

    vecs[0] = '{32'd125,  1'b0, 32'd8192};
    vecs[1] = '{32'd250,  1'b0, 32'd16384};
    vecs[2] = '{32'd1,    1'b0, 32'd65};
    vecs[3] = '{32'd333,  1'b0, 32'd21823};
    vecs[4] = '{32'd501,  1'b1, 32'd21823};
    vecs[5] = '{32'd0,    1'b0, 32'd0};
    vecs[6] = '{32'd1000, 1'b1, 32'd0};
    vecs[7] = '{32'd7,    1'b0, 32'd458};
    vecs[8] = '{32'd500,  1'b0, 32'd32768};

    rst_n         = 1'b0;
    en            = 1'b0;
    rq.freq_hz    = '0;
    rq.freq_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", rq.freq_ready, 1);
    chk("rst_err", rq.freq_err, 0);
    chk("rst_sig", sig_out, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_inc", cur_inc, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge sys_clk);

    // T1: ready low 17 cycles, then 8-cycle period, 4 low / 4 high
    request(32'd125);
    n = 0;
    while (!rq.freq_ready && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    chk("t1_busy_cycles", n, 17);
    chk("t1_inc", cur_inc, 8192);
    n = 0;
    while (!period_tick && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t1_tick_seen", period_tick, 1);
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      pat[i] = sig_out;
      if (i > 0 && period_tick) cnt_b++;
      @(negedge sys_clk);
    end
    chk("t1_pattern", pat, 8'hF0);
    chk("t1_mid_ticks", cnt_b, 0);
    chk("t1_period_tick", period_tick, 1);

    // T2: switch to 500, commit coincides with a wrap
    request(32'd500);
    wait_ready(100, "t2_timeout");
    chk("t2_commit_on_tick", period_tick, 1);
    chk("t2_inc", cur_inc, 32768);
    chk("t2_sig_at_commit", sig_out, 0);
    prev  = sig_out;
    cnt_a = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge sys_clk);
      if (sig_out != prev) cnt_a++;
      prev = sig_out;
    end
    chk("t2_toggles", cnt_a, 7);

    // T3: rejection, and requests during DIV are ignored
    request(32'd501);
    chk("t3_err", rq.freq_err, 1);
    chk("t3_ready", rq.freq_ready, 1);
    chk("t3_inc_kept", cur_inc, 32768);
    @(negedge sys_clk);
    chk("t3_err_one_cycle", rq.freq_err, 0);
    request(32'd125);
    rq.freq_hz    = 32'd250;
    rq.freq_valid = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (rq.freq_err) cnt_a++;
    end
    rq.freq_valid = 1'b0;
    wait_ready(100, "t3_timeout");
    chk("t3_div_err", cnt_a, 0);
    chk("t3_inc", cur_inc, 8192);

    // T4: request 0 gives a clean stop after the next wrap
    request(32'd0);
    wait_ready(100, "t4_timeout");
    chk("t4_inc", cur_inc, 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (sig_out) cnt_a++;
      if (period_tick && i > 0) cnt_b++;
      @(negedge sys_clk);
    end
    chk("t4_sig_high", cnt_a, 0);
    chk("t4_ticks", cnt_b, 0);

    // T5a: reset mid-division
    request(32'd250);
    wait_ready(100, "t5_pre_timeout");
    chk("t5_pre_inc", cur_inc, 16384);
    request(32'd125);
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("t5_rst_ready", rq.freq_ready, 1);
    chk("t5_rst_err", rq.freq_err, 0);
    chk("t5_rst_sig", sig_out, 0);
    chk("t5_rst_tick", period_tick, 0);
    chk("t5_rst_inc", cur_inc, 0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // T5b: en=0 while pending commits at once
    request(32'd125);
    wait_ready(100, "t5_run_timeout");
    chk("t5_run_inc", cur_inc, 8192);
    request(32'd500);
    repeat (16) @(negedge sys_clk);
    chk("t5_pend_busy", rq.freq_ready, 0);
    en = 1'b0;
    @(negedge sys_clk);
    chk("t5_en0_ready", rq.freq_ready, 1);
    chk("t5_en0_inc", cur_inc, 32768);
    chk("t5_en0_sig", sig_out, 0);
    en = 1'b1;
    @(negedge sys_clk);
    chk("t5_resume_sig", sig_out, 1);

    // Table of requests
    foreach (vecs[i]) begin
      request(vecs[i].hz);
      chk($sformatf("vec%0d_err", i), rq.freq_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_ready", i), rq.freq_ready, vecs[i].exp_err);
      wait_ready(3000, $sformatf("vec%0d_timeout", i));
      chk($sformatf("vec%0d_inc", i), cur_inc, vecs[i].exp_inc);
      @(negedge sys_clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
